// File: rtl/encoder_pkg.sv
// Shared constants for the encoder homing controller: register map, bit
// positions, FSM encoding and small bus helpers.
package encoder_pkg;

  localparam logic [31:0] ENC_ID_VALUE = 32'hEA680004;

  localparam logic [2:0] ADDR_ID        = 3'd0;
  localparam logic [2:0] ADDR_CTRL      = 3'd1;
  localparam logic [2:0] ADDR_STATUS    = 3'd2;
  localparam logic [2:0] ADDR_POSITION  = 3'd3;
  localparam logic [2:0] ADDR_TIMEOUT   = 3'd4;
  localparam logic [2:0] ADDR_INDEX_CAP = 3'd5;
  localparam logic [2:0] ADDR_COMPARE   = 3'd6;

  localparam int unsigned CTRL_HOME_START = 0;
  localparam int unsigned CTRL_ABORT      = 1;
  localparam int unsigned CTRL_DIR_INV    = 2;

  localparam int unsigned STAT_HOMED    = 3;
  localparam int unsigned STAT_TMO_ERR  = 4;
  localparam int unsigned STAT_QUAD_ERR = 5;
  localparam int unsigned STAT_PEND_LSB = 8;
  localparam int unsigned STAT_EN_LSB   = 16;

  localparam int unsigned IRQ_W     = 4;
  localparam int unsigned IRQ_INDEX = 0;
  localparam int unsigned IRQ_CMP   = 1;
  localparam int unsigned IRQ_DONE  = 2;
  localparam int unsigned IRQ_FAIL  = 3;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SEEK = 3'd1;
  localparam logic [2:0] ST_ZERO = 3'd2;
  localparam logic [2:0] ST_DONE = 3'd3;
  localparam logic [2:0] ST_FAIL = 3'd4;

  // Replace only the byte lanes whose enable is set.
  function automatic logic [31:0] be_merge(input logic [31:0] cur,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) begin
      m[i*8 +: 8] = be[i] ? wdata[i*8 +: 8] : cur[i*8 +: 8];
    end
    return m;
  endfunction

  // Quadrature phase as a 2-bit ring position: 00->0, 01->1, 11->2, 10->3.
  function automatic logic [1:0] gray2bin(input logic a, input logic b);
    return {a, a ^ b};
  endfunction

endpackage

// File: rtl/encoder_homing_ctrl_quad.sv
// Synchronises the raw A/B/Z inputs and decodes x4 quadrature steps,
// illegal double transitions and rising edges of the index pulse.
module quad_decoder
  import encoder_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic a_i,
  input  logic b_i,
  input  logic z_i,
  output logic step_c_o,
  output logic dir_c_o,
  output logic idx_rise_c_o,
  output logic quad_err_c_o
);

  localparam int unsigned SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [SS-1:0] a_sync_q, b_sync_q, z_sync_q;
  logic          a_prev_q, b_prev_q, z_prev_q;
  logic [1:0]    delta;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_sync_q <= '0;
      b_sync_q <= '0;
      z_sync_q <= '0;
      a_prev_q <= 1'b0;
      b_prev_q <= 1'b0;
      z_prev_q <= 1'b0;
    end else begin
      a_sync_q <= {a_sync_q[SS-2:0], a_i};
      b_sync_q <= {b_sync_q[SS-2:0], b_i};
      z_sync_q <= {z_sync_q[SS-2:0], z_i};
      a_prev_q <= a_sync_q[SS-1];
      b_prev_q <= b_sync_q[SS-1];
      z_prev_q <= z_sync_q[SS-1];
    end
  end

  // Ring distance: 1 = forward, 3 = reverse, 2 = both phases moved at once.
  always_comb begin
    delta        = gray2bin(a_sync_q[SS-1], b_sync_q[SS-1]) - gray2bin(a_prev_q, b_prev_q);
    step_c_o     = delta[0];
    dir_c_o      = (delta == 2'd3);
    quad_err_c_o = (delta == 2'd2);
    idx_rise_c_o = z_sync_q[SS-1] & ~z_prev_q;
  end

endmodule

// File: rtl/encoder_homing_ctrl.sv
// Avalon-MM quadrature position controller: position counter, index capture,
// compare match, Z-index homing sequencer and level interrupt.
module encoder_homing_ctrl
  import encoder_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned POS_W       = 32,
  parameter logic [31:0] TIMEOUT_RST = 32'd50000000,
  parameter logic [31:0] ID_VALUE    = encoder_pkg::ENC_ID_VALUE
) (
  input  logic        csi_MCLK_clk,
  input  logic        rsi_MRST_reset_n,
  input  logic [31:0] avs_ctrl_writedata,
  output logic [31:0] avs_ctrl_readdata,
  input  logic [3:0]  avs_ctrl_byteenable,
  input  logic [2:0]  avs_ctrl_address,
  input  logic        avs_ctrl_write,
  input  logic        avs_ctrl_read,
  output logic        avs_ctrl_waitrequest,
  input  logic        A,
  input  logic        B,
  input  logic        Z,
  output logic        ins_irq_irq,
  output logic        coe_homing_busy
);

  logic step_c, dir_c, idx_rise_c, quad_err_c;

  logic [2:0]       state_q, state_d;
  logic [31:0]      timer_q, timer_d;
  logic             homed_q, homed_d;
  logic             tmo_err_q, tmo_err_d;
  logic             quad_err_q, quad_err_d;
  logic             dir_inv_q, dir_inv_d;
  logic [POS_W-1:0] position_q, position_d;
  logic [POS_W-1:0] index_cap_q, index_cap_d;
  logic [POS_W-1:0] compare_q, compare_d;
  logic [31:0]      timeout_q, timeout_d;
  logic [IRQ_W-1:0] pend_q, pend_d;
  logic [IRQ_W-1:0] en_q, en_d;
  logic             match_q, match_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;
  logic             busy_q, busy_d;

  logic             wr_ctrl, home_start, abort, idle_like;
  logic             zero_pos, ev_done, ev_fail;
  logic [IRQ_W-1:0] ev, w1c;
  logic [31:0]      pos_ext, status_w;

  quad_decoder #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_quad (
    .clk_i        (csi_MCLK_clk),
    .rst_ni       (rsi_MRST_reset_n),
    .a_i          (A),
    .b_i          (B),
    .z_i          (Z),
    .step_c_o     (step_c),
    .dir_c_o      (dir_c),
    .idx_rise_c_o (idx_rise_c),
    .quad_err_c_o (quad_err_c)
  );

  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      homed_q     <= 1'b0;
      tmo_err_q   <= 1'b0;
      quad_err_q  <= 1'b0;
      dir_inv_q   <= 1'b0;
      position_q  <= '0;
      index_cap_q <= '0;
      compare_q   <= '0;
      timeout_q   <= TIMEOUT_RST;
      pend_q      <= '0;
      en_q        <= '0;
      match_q     <= 1'b1;
      readdata_q  <= '0;
      irq_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      homed_q     <= homed_d;
      tmo_err_q   <= tmo_err_d;
      quad_err_q  <= quad_err_d;
      dir_inv_q   <= dir_inv_d;
      position_q  <= position_d;
      index_cap_q <= index_cap_d;
      compare_q   <= compare_d;
      timeout_q   <= timeout_d;
      pend_q      <= pend_d;
      en_q        <= en_d;
      match_q     <= match_d;
      readdata_q  <= readdata_d;
      irq_q       <= irq_d;
      busy_q      <= busy_d;
    end
  end

  // Homing sequencer; a zero timer in SEEK means the timeout is disabled.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    homed_d   = homed_q;
    tmo_err_d = tmo_err_q;
    zero_pos  = 1'b0;
    ev_done   = 1'b0;
    ev_fail   = 1'b0;
    wr_ctrl    = avs_ctrl_write && (avs_ctrl_address == ADDR_CTRL) && avs_ctrl_byteenable[0];
    home_start = wr_ctrl && avs_ctrl_writedata[CTRL_HOME_START];
    abort      = wr_ctrl && avs_ctrl_writedata[CTRL_ABORT];
    if (abort) begin
      state_d = ST_IDLE;
      homed_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_FAIL: begin
          if (home_start) begin
            state_d   = ST_SEEK;
            homed_d   = 1'b0;
            tmo_err_d = 1'b0;
            timer_d   = timeout_q;
          end
        end
        ST_SEEK: begin
          if (idx_rise_c) begin
            state_d = ST_ZERO;
          end else if (timer_q == 32'd1) begin
            state_d   = ST_FAIL;
            timer_d   = '0;
            tmo_err_d = 1'b1;
            ev_fail   = 1'b1;
          end else if (timer_q != 32'd0) begin
            timer_d = timer_q - 32'd1;
          end
        end
        ST_ZERO: begin
          zero_pos = 1'b1;
          state_d  = ST_DONE;
          homed_d  = 1'b1;
          ev_done  = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Register file, position datapath, compare edge and interrupt.
  always_comb begin
    idle_like   = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_FAIL);
    pos_ext     = 32'($signed(position_q));
    dir_inv_d   = dir_inv_q;
    position_d  = position_q;
    index_cap_d = index_cap_q;
    compare_d   = compare_q;
    timeout_d   = timeout_q;
    en_d        = en_q;
    w1c         = '0;
    quad_err_d  = quad_err_q | quad_err_c;
    readdata_d  = '0;
    status_w    = '0;

    if (wr_ctrl) dir_inv_d = avs_ctrl_writedata[CTRL_DIR_INV];

    if (zero_pos) begin
      position_d = '0;
    end else if (avs_ctrl_write && (avs_ctrl_address == ADDR_POSITION) && idle_like) begin
      position_d = POS_W'(be_merge(pos_ext, avs_ctrl_writedata, avs_ctrl_byteenable));
    end else if (step_c) begin
      position_d = (dir_c ^ dir_inv_q) ? position_q - POS_W'(1) : position_q + POS_W'(1);
    end

    if (idx_rise_c) index_cap_d = position_q;

    if (avs_ctrl_write) begin
      case (avs_ctrl_address)
        ADDR_STATUS: begin
          if (avs_ctrl_byteenable[1]) w1c  = avs_ctrl_writedata[STAT_PEND_LSB +: IRQ_W];
          if (avs_ctrl_byteenable[2]) en_d = avs_ctrl_writedata[STAT_EN_LSB +: IRQ_W];
        end
        ADDR_TIMEOUT: timeout_d = be_merge(timeout_q, avs_ctrl_writedata, avs_ctrl_byteenable);
        ADDR_COMPARE: compare_d = POS_W'(be_merge(32'($signed(compare_q)), avs_ctrl_writedata,
                                                  avs_ctrl_byteenable));
        default: ;
      endcase
    end

    match_d       = (position_d == compare_d);
    ev            = '0;
    ev[IRQ_INDEX] = idx_rise_c;
    ev[IRQ_CMP]   = match_d & ~match_q;
    ev[IRQ_DONE]  = ev_done;
    ev[IRQ_FAIL]  = ev_fail;
    pend_d        = (pend_q & ~w1c) | ev;

    irq_d  = |(pend_d & en_d);
    busy_d = (state_d == ST_SEEK) || (state_d == ST_ZERO);

    status_w[2:0]                    = state_q;
    status_w[STAT_HOMED]             = homed_q;
    status_w[STAT_TMO_ERR]           = tmo_err_q;
    status_w[STAT_QUAD_ERR]          = quad_err_q;
    status_w[STAT_PEND_LSB +: IRQ_W] = pend_q;
    status_w[STAT_EN_LSB +: IRQ_W]   = en_q;

    if (avs_ctrl_read) begin
      case (avs_ctrl_address)
        ADDR_ID:        readdata_d = ID_VALUE;
        ADDR_CTRL:      readdata_d[CTRL_DIR_INV] = dir_inv_q;
        ADDR_STATUS:    readdata_d = status_w;
        ADDR_POSITION:  readdata_d = pos_ext;
        ADDR_TIMEOUT:   readdata_d = timeout_q;
        ADDR_INDEX_CAP: readdata_d = 32'($signed(index_cap_q));
        ADDR_COMPARE:   readdata_d = 32'($signed(compare_q));
        default:        readdata_d = '0;
      endcase
    end
  end

  assign avs_ctrl_readdata    = readdata_q;
  assign avs_ctrl_waitrequest = 1'b0;
  assign ins_irq_irq          = irq_q;
  assign coe_homing_busy      = busy_q;

endmodule

// File: tb/tb_encoder_homing_ctrl.sv
// Self-checking bench for encoder_homing_ctrl against an event-level model
// of the register map, position counter and homing outcomes.
module tb_encoder_homing_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [3:0]  be = '0;
  logic [2:0]  addr = '0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic        waitreq;
  logic        enc_a = 1'b0, enc_b = 1'b0, enc_z = 1'b0;
  logic        irq, busy;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] m_pos, m_cmp, m_timeout, m_cap;
  logic [3:0]  m_pend, m_en;
  logic        m_dir_inv, m_homed, m_tmo, m_qerr, m_eq;
  int          m_state;

  logic [1:0] gray_seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  int         ab_idx = 0;

  encoder_homing_ctrl dut (
    .csi_MCLK_clk         (clk),
    .rsi_MRST_reset_n     (rst_n),
    .avs_ctrl_writedata   (wdata),
    .avs_ctrl_readdata    (rdata),
    .avs_ctrl_byteenable  (be),
    .avs_ctrl_address     (addr),
    .avs_ctrl_write       (wr),
    .avs_ctrl_read        (rd),
    .avs_ctrl_waitrequest (waitreq),
    .A                    (enc_a),
    .B                    (enc_b),
    .Z                    (enc_z),
    .ins_irq_irq          (irq),
    .coe_homing_busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s = '0;
    s[2:0]   = 3'(m_state);
    s[3]     = m_homed;
    s[4]     = m_tmo;
    s[5]     = m_qerr;
    s[11:8]  = m_pend;
    s[19:16] = m_en;
    return s;
  endfunction

  function automatic logic m_busy();
    return (m_state == 1) || (m_state == 2);
  endfunction

  task automatic m_reset();
    m_pos = '0; m_cmp = '0; m_cap = '0; m_timeout = 32'd50000000;
    m_pend = '0; m_en = '0; m_dir_inv = 1'b0;
    m_homed = 1'b0; m_tmo = 1'b0; m_qerr = 1'b0; m_state = 0;
    m_eq = 1'b1;
  endtask

  // Compare interrupt fires when position/compare become equal.
  task automatic m_touch();
    logic eq;
    eq = (m_pos == m_cmp);
    if (eq && !m_eq) m_pend[1] = 1'b1;
    m_eq = eq;
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] b);
    @(negedge clk);
    addr = a; wdata = d; be = b; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0; be = '0;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a; rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    d = rdata;
  endtask

  task automatic wr_pos(input logic [31:0] v);
    bus_wr(3'd3, v, 4'hF);
    if (!m_busy()) begin
      m_pos = v;
      m_touch();
    end
  endtask

  task automatic wr_cmp(input logic [31:0] v);
    bus_wr(3'd6, v, 4'hF);
    m_cmp = v;
    m_touch();
  endtask

  task automatic wr_timeout(input logic [31:0] v, input logic [3:0] b);
    bus_wr(3'd4, v, b);
    for (int i = 0; i < 4; i++) if (b[i]) m_timeout[i*8 +: 8] = v[i*8 +: 8];
  endtask

  task automatic wr_status(input logic [3:0] en, input logic [3:0] clr);
    bus_wr(3'd2, {12'b0, en, 4'b0, clr, 8'b0}, 4'b0110);
    m_pend = m_pend & ~clr;
    m_en = en;
  endtask

  task automatic wr_ctrl(input logic home, input logic abrt, input logic inv);
    bus_wr(3'd1, {29'b0, inv, abrt, home}, 4'b0001);
    m_dir_inv = inv;
    if (abrt) begin
      m_state = 0;
      m_homed = 1'b0;
    end else if (home && !m_busy()) begin
      m_state = 1;
      m_homed = 1'b0;
      m_tmo = 1'b0;
    end
  endtask

  // One physical quadrature edge; forward follows 00->01->11->10.
  task automatic quad_step(input logic fwd);
    ab_idx = (ab_idx + (fwd ? 1 : 3)) % 4;
    @(negedge clk);
    {enc_a, enc_b} = gray_seq[ab_idx];
    repeat (4) @(negedge clk);
    m_pos = m_pos + ((fwd != m_dir_inv) ? 32'd1 : 32'hFFFFFFFF);
    m_touch();
  endtask

  task automatic chk_all(input string tag);
    logic [31:0] d;
    bus_rd(3'd3, d);
    chk_eq({tag, "/pos"}, d, m_pos);
    bus_rd(3'd2, d);
    chk_eq({tag, "/status"}, d, m_status());
    chk_eq({tag, "/irq"}, 32'(irq), 32'(|(m_pend & m_en)));
    chk_eq({tag, "/busy"}, 32'(busy), 32'(m_busy()));
    chk_eq({tag, "/waitreq"}, 32'(waitreq), 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    m_reset();

    // Reset state
    repeat (3) @(negedge clk);
    chk_eq("rst/irq", 32'(irq), 32'd0);
    chk_eq("rst/busy", 32'(busy), 32'd0);
    chk_eq("rst/rdata", rdata, 32'd0);
    rst_n = 1'b1;
    bus_rd(3'd0, d);
    chk_eq("rst/id", d, 32'hEA680004);
    bus_rd(3'd4, d);
    chk_eq("rst/timeout", d, m_timeout);
    chk_all("rst");

    // Forward count then inverted direction
    for (int i = 0; i < 400; i++) quad_step(1'b1);
    chk_all("fwd400");
    wr_ctrl(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 400; i++) quad_step(1'b1);
    chk_all("inv400");

    // Wrap boundaries
    wr_ctrl(1'b0, 1'b0, 1'b0);
    wr_pos(32'd0);
    quad_step(1'b0);
    chk_all("wrap_neg");
    wr_pos(32'h7FFFFFFF);
    quad_step(1'b1);
    chk_all("wrap_pos");

    // Successful homing on Z at cycle 300
    wr_status(4'b0100, 4'hF);
    wr_pos(32'd123);
    wr_timeout(32'd1000, 4'hF);
    wr_ctrl(1'b1, 1'b0, 1'b0);
    repeat (298) @(negedge clk);
    chk_eq("home/busy_seek", 32'(busy), 32'd1);
    @(negedge clk);
    enc_z = 1'b1;
    repeat (3) @(negedge clk);
    enc_z = 1'b0;
    repeat (8) @(negedge clk);
    m_cap = m_pos;
    m_pend[0] = 1'b1;
    m_pos = '0;
    m_touch();
    m_state = 3;
    m_homed = 1'b1;
    m_pend[2] = 1'b1;
    bus_rd(3'd5, d);
    chk_eq("home/index_cap", d, m_cap);
    chk_all("home_done");
    wr_status(4'b0100, 4'b0100);
    chk_all("home_w1c");

    // Homing timeout, exact cycle
    wr_status(4'b1100, 4'hF);
    wr_timeout(32'd50, 4'hF);
    wr_ctrl(1'b1, 1'b0, 1'b0);
    repeat (49) @(negedge clk);
    chk_eq("tmo/busy49", 32'(busy), 32'd1);
    @(negedge clk);
    chk_eq("tmo/busy50", 32'(busy), 32'd0);
    m_state = 4;
    m_tmo = 1'b1;
    m_pend[3] = 1'b1;
    chk_all("tmo_fail");
    wr_ctrl(1'b0, 1'b1, 1'b0);
    chk_all("tmo_abort");
    wr_ctrl(1'b1, 1'b1, 1'b0);
    chk_all("start_abort_same");

    // Illegal double transition
    ab_idx = (ab_idx + 2) % 4;
    @(negedge clk);
    {enc_a, enc_b} = gray_seq[ab_idx];
    repeat (4) @(negedge clk);
    m_qerr = 1'b1;
    chk_all("quad_err");

    // Compare edge fires once
    wr_pos(32'd0);
    wr_cmp(32'd5);
    for (int i = 0; i < 5; i++) quad_step(1'b1);
    chk_all("cmp_hit");
    wr_status(m_en, 4'b0010);
    repeat (10) @(negedge clk);
    chk_all("cmp_once");

    // Reset while seeking
    wr_timeout(32'd0, 4'hF);
    wr_ctrl(1'b1, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    chk_eq("rstseek/busy_pre", 32'(busy), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    enc_a = 1'b0; enc_b = 1'b0; ab_idx = 0;
    #1;
    chk_eq("rstseek/busy", 32'(busy), 32'd0);
    chk_eq("rstseek/irq", 32'(irq), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    chk_all("rstseek");
    bus_rd(3'd4, d);
    chk_eq("rstseek/timeout", d, m_timeout);

    // Randomised register and motion traffic
    for (int it = 0; it < 50; it++) begin
      case ($urandom_range(0, 5))
        0: begin
          int n;
          logic f;
          n = $urandom_range(1, 6);
          f = 1'($urandom_range(0, 1));
          for (int k = 0; k < n; k++) quad_step(f);
        end
        1: wr_ctrl(1'b0, 1'b0, 1'($urandom_range(0, 1)));
        2: wr_cmp(m_pos + 32'($urandom_range(0, 8)) - 32'd4);
        3: wr_status(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        4: wr_pos($urandom);
        default: begin
          wr_timeout($urandom, 4'($urandom_range(0, 15)));
          bus_rd(3'd4, d);
          chk_eq("rand/timeout", d, m_timeout);
        end
      endcase
      chk_all("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
